// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline stage: valid/ready handshake with a 2-entry skid buffer,
// flush that zeroes control, and saturating stall/bubble counters.
// The head (main) register drives the outputs. The skid register catches one
// extra entry when execute stalls. Control is forced to zero on every bubble.
module id_ex_pipe_stage #(
  parameter int unsigned DATA_W          = 160,
  parameter int unsigned CTRL_W          = 16,
  parameter bit          FLUSH_ZERO_DATA = 1'b1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state, state_next;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  // State register; reset wins over flush and any transfer.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= EMPTY;
    else         state <= state_next;
  end

  // Next-state logic: flush empties the stage, otherwise track occupancy.
  // NOTE: state_next gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY:   if (in_fire) state_next = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_next = FULL;
          else if (!in_fire && out_fire) state_next = EMPTY;
        end
        FULL:    if (out_fire) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Handshake outputs decoded purely from the state register.
  always_comb begin
    out_valid_o = (state != EMPTY);
    in_ready_o  = (state != FULL);
  end

  assign out_data_o = main_data;
  assign out_ctrl_o = main_ctrl;

  // Payload registers: capture, shift skid->main, and clear ctrl on bubbles.
  // NOTE: the payload registers are reset explicitly so out_ctrl_o is
  // provably zero from the first cycle; they are flops, not a RAM.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush_i) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
      if (FLUSH_ZERO_DATA) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_data <= in_data_i;
            main_ctrl <= in_ctrl_i;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data <= in_data_i;
            main_ctrl <= in_ctrl_i;
          end else if (in_fire) begin
            skid_data <= in_data_i;
            skid_ctrl <= in_ctrl_i;
          end else if (out_fire) begin
            main_ctrl <= '0;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            skid_ctrl <= '0;
          end
        end
        default: begin
          main_ctrl <= '0;
          skid_ctrl <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (out_valid_o && !out_ready_i && (stall_cnt_o != CNT_MAX))
        stall_cnt_o <= stall_cnt_o + CNT_ONE;
      if (!out_valid_o && (bubble_cnt_o != CNT_MAX))
        bubble_cnt_o <= bubble_cnt_o + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed testbench for id_ex_pipe_stage (CNT_W=4 so saturation is reachable).
module tb_id_ex_pipe_stage;

  localparam int DATA_W = 160;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  int errors = 0;
  int checks = 0;

  id_ex_pipe_stage #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .FLUSH_ZERO_DATA(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_ctrl_o(out_ctrl),
    .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] pat(input logic [31:0] k);
    return {5{32'hA500_0000 | k}};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    flush = 0; in_valid = 0; in_data = '0; in_ctrl = '0; out_ready = 0; rst_n = 0;

    // Reset with junk on the input.
    in_valid = 1; in_ctrl = 16'hFFFF; in_data = '1; out_ready = 1;
    tick(); tick();
    check("rst_out_valid", DATA_W'(out_valid), '0);
    check("rst_out_ctrl",  DATA_W'(out_ctrl), '0);
    check("rst_out_data",  out_data, '0);
    check("rst_in_ready",  DATA_W'(in_ready), DATA_W'(1));
    check("rst_stall",     DATA_W'(stall_cnt), '0);
    check("rst_bubble",    DATA_W'(bubble_cnt), '0);
    rst_n = 1; in_valid = 0;

    // Streaming 1..4 with out_ready high.
    out_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1; in_ctrl = CTRL_W'(k); in_data = pat(k);
      tick();
      check($sformatf("strm_valid_%0d", k), DATA_W'(out_valid), DATA_W'(1));
      check($sformatf("strm_ctrl_%0d", k),  DATA_W'(out_ctrl), DATA_W'(k));
      check($sformatf("strm_data_%0d", k),  out_data, pat(k));
      check($sformatf("strm_ready_%0d", k), DATA_W'(in_ready), DATA_W'(1));
    end
    in_valid = 0;
    tick();
    check("strm_drain_valid", DATA_W'(out_valid), '0);
    check("strm_drain_ctrl",  DATA_W'(out_ctrl), '0);
    check("strm_stall",       DATA_W'(stall_cnt), '0);
    check("strm_bubble",      DATA_W'(bubble_cnt), DATA_W'(1));

    // Back-pressure: A then B, hold, then release.
    do_reset();
    out_ready = 0;
    in_valid = 1; in_ctrl = 16'h000A; in_data = pat(32'hA);
    tick();
    check("bp_a_ctrl",  DATA_W'(out_ctrl), DATA_W'(16'h000A));
    check("bp_a_ready", DATA_W'(in_ready), DATA_W'(1));
    in_ctrl = 16'h000B; in_data = pat(32'hB);
    tick();
    check("bp_full_ready", DATA_W'(in_ready), '0);
    check("bp_full_ctrl",  DATA_W'(out_ctrl), DATA_W'(16'h000A));
    in_ctrl = 16'h000E; in_data = pat(32'hE);  // must not be captured
    tick(); tick(); tick();
    check("bp_stall4",     DATA_W'(stall_cnt), DATA_W'(4));
    check("bp_hold_ready", DATA_W'(in_ready), '0);
    check("bp_hold_data",  out_data, pat(32'hA));
    in_valid = 0; out_ready = 1;
    tick();
    check("bp_b_ctrl",  DATA_W'(out_ctrl), DATA_W'(16'h000B));
    check("bp_b_data",  out_data, pat(32'hB));
    check("bp_b_ready", DATA_W'(in_ready), DATA_W'(1));
    check("bp_b_stall", DATA_W'(stall_cnt), DATA_W'(4));
    tick();
    check("bp_end_valid", DATA_W'(out_valid), '0);
    check("bp_end_ctrl",  DATA_W'(out_ctrl), '0);

    // Flush while FULL with C presented.
    do_reset();
    out_ready = 0;
    in_valid = 1; in_ctrl = 16'h0005; in_data = pat(5);
    tick();
    in_ctrl = 16'h0006; in_data = pat(6);
    tick();
    check("fl_full_ready", DATA_W'(in_ready), '0);
    in_ctrl = 16'h0007; in_data = pat(7); flush = 1;
    tick();
    check("fl_valid", DATA_W'(out_valid), '0);
    check("fl_ctrl",  DATA_W'(out_ctrl), '0);
    check("fl_data",  out_data, '0);
    check("fl_ready", DATA_W'(in_ready), DATA_W'(1));
    flush = 0; in_valid = 0; out_ready = 1;
    tick(); tick();
    check("fl_no_c_valid", DATA_W'(out_valid), '0);
    check("fl_no_c_ctrl",  DATA_W'(out_ctrl), '0);

    // Flush together with out_fire in ONE (head D).
    out_ready = 0;
    in_valid = 1; in_ctrl = 16'h0009; in_data = pat(9);
    tick();
    check("fd_head_ctrl", DATA_W'(out_ctrl), DATA_W'(16'h0009));
    in_valid = 0; flush = 1; out_ready = 1;
    tick();
    check("fd_valid", DATA_W'(out_valid), '0);
    flush = 0;
    tick();
    check("fd_no_repeat", DATA_W'(out_valid), '0);
    check("fd_ctrl",      DATA_W'(out_ctrl), '0);

    // Bubble counter saturation and reset clear.
    do_reset();
    out_ready = 0; in_valid = 0;
    for (int i = 0; i < 20; i++) tick();
    check("sat_bubble", DATA_W'(bubble_cnt), DATA_W'(4'hF));
    tick();
    check("sat_hold", DATA_W'(bubble_cnt), DATA_W'(4'hF));
    check("sat_stall", DATA_W'(stall_cnt), '0);
    rst_n = 0;
    tick();
    check("sat_clear", DATA_W'(bubble_cnt), '0);
    rst_n = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule
